// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one word request
// outstanding, and buffers returned {pc, inst} pairs in a FIFO for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_next_s;
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   inst_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_after_pop_s;
    logic [CW-1:0] count_after_push_pop_s;
    logic          push_s;
    logic          pop_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return ptr + AW'(1);
    endfunction

    assign imem_req    = (state_r == REQ);
    assign imem_addr   = fetch_pc_r;
    assign out_valid   = (count_r != {CW{1'b0}}) && !redirect;
    assign out_inst    = inst_mem_r[rd_ptr_r];
    assign out_pc      = pc_mem_r[rd_ptr_r];
    assign out_next_pc = pc_mem_r[rd_ptr_r] + 32'd4;

    // A response is only kept when it answers a live request; redirect kills it.
    assign pop_s  = out_valid && out_ready;
    assign push_s = (state_r == WAIT) && imem_rvalid && !redirect;

    // Occupancy seen by the space rule, including this cycle's push/pop.
    always_comb begin
        count_after_pop_s      = count_r - {{(CW-1){1'b0}}, pop_s};
        count_after_push_pop_s = count_after_pop_s + {{(CW-1){1'b0}}, push_s};
    end

    // Next fetch state; redirect outranks every other event of the cycle.
    always_comb begin
        state_next_s = state_r;
        if (redirect) begin
            case (state_r)
                IDLE:    state_next_s = REQ;
                REQ:     state_next_s = imem_gnt ? DROP : REQ;
                WAIT:    state_next_s = imem_rvalid ? REQ : DROP;
                DROP:    state_next_s = imem_rvalid ? REQ : DROP;
                default: state_next_s = REQ;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_after_pop_s < FULL_C) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                REQ:     state_next_s = imem_gnt ? WAIT : REQ;
                WAIT: begin
                    if (!imem_rvalid) begin
                        state_next_s = WAIT;
                    end else if (count_after_push_pop_s < FULL_C) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DROP:    state_next_s = imem_rvalid ? REQ : DROP;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Next fetch address: redirect target, else advance after a kept response.
    always_comb begin
        fetch_pc_next_s = fetch_pc_r;
        if (redirect) begin
            fetch_pc_next_s = word_align(redirect_pc);
        end else if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
        end
    end

    // FIFO storage, pointers and occupancy; redirect empties the queue.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                inst_mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
                inst_mem_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_after_push_pop_s;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a randomized memory responder, a
// transaction-level monitor model and one task per scenario.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        CLK, RST;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc, out_next_pc;

    int checks = 0;
    int errors = 0;

    // responder configuration and state
    int          gnt_pct = 100, dly_min = 0, dly_max = 0;
    bit          rsp_pending = 0, r_acc, r_done;
    int          rsp_wait;
    logic [31:0] rsp_addr, r_addr;

    // monitor model state
    bit          mon_en = 0, m_pend = 0, m_stale = 0, m_hold = 0;
    bit          mv_rv, mv_acc, mv_pop, mv_push;
    int          m_count = 0, grants = 0, anom_cnt = 0, anom_code = 0;
    logic [31:0] m_exp_fetch, m_hold_addr, last_acc;
    logic [31:0] pop_pc_q[$], pop_inst_q[$], pop_next_q[$];

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_next_pc(out_next_pc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic note_anomaly(input int code);
        anom_cnt++;
        if (anom_code == 0) anom_code = code;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] addr);
        redirect    = 1'b1;
        redirect_pc = addr;
        cyc(1);
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    task automatic clear_pops();
        pop_pc_q.delete();
        pop_inst_q.delete();
        pop_next_q.delete();
    endtask

    // Memory: grants when idle, answers each accepted request after a random delay.
    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            r_acc  = (imem_req === 1'b1) && (imem_gnt === 1'b1) && (RST === 1'b0);
            r_addr = imem_addr;
            r_done = (imem_rvalid === 1'b1);
            @(posedge CLK); #1;
            if (r_done) rsp_pending = 0;
            if (r_acc) begin
                rsp_pending = 1;
                rsp_addr    = r_addr;
                rsp_wait    = $urandom_range(dly_max, dly_min);
            end
            if (rsp_pending && rsp_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rsp_addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
                if (rsp_pending) rsp_wait--;
            end
            imem_gnt = !rsp_pending && ($urandom_range(99, 0) < gnt_pct);
        end
    end

    // Transaction model: queue occupancy, outstanding request, expected fetch address.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST === 1'b1) begin
                mon_en = 1; m_count = 0; m_pend = 0; m_stale = 0; m_hold = 0;
                m_exp_fetch = RPC;
                clear_pops();
            end else if (mon_en) begin
                if (out_valid !== ((m_count != 0) && !redirect)) note_anomaly(1);
                if (imem_req === 1'b1 && m_count == DEPTH) note_anomaly(2);
                if (imem_addr[1:0] !== 2'b00) note_anomaly(3);
                if (m_hold && (imem_req !== 1'b1 || imem_addr !== m_hold_addr)) note_anomaly(4);
                mv_rv  = (imem_rvalid === 1'b1) && m_pend;
                mv_acc = (imem_req === 1'b1) && (imem_gnt === 1'b1);
                mv_pop = (out_valid === 1'b1) && (out_ready === 1'b1);
                if (mv_acc && m_pend) note_anomaly(5);
                if (mv_pop) begin
                    pop_pc_q.push_back(out_pc);
                    pop_inst_q.push_back(out_inst);
                    pop_next_q.push_back(out_next_pc);
                end
                if (redirect) begin
                    m_count     = 0;
                    m_exp_fetch = redirect_pc & 32'hFFFF_FFFC;
                    if (mv_rv) m_pend = 0;
                    else if (m_pend) m_stale = 1;
                    m_hold = 0;
                end else begin
                    mv_push = mv_rv && !m_stale;
                    m_count = m_count + int'(mv_push) - int'(mv_pop);
                    if (mv_push) m_exp_fetch = m_exp_fetch + 32'd4;
                    if (mv_rv) begin m_pend = 0; m_stale = 0; end
                    if (mv_acc && imem_addr !== m_exp_fetch) note_anomaly(6);
                    m_hold      = (imem_req === 1'b1) && (imem_gnt !== 1'b1);
                    m_hold_addr = imem_addr;
                end
                if (mv_acc) begin
                    m_pend   = 1;
                    m_stale  = redirect;
                    grants++;
                    last_acc = imem_addr;
                end
            end
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        cyc(2);
        @(negedge CLK);
        checks += 6;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset imem_req: got %b, want 0", imem_req); end
        if (imem_addr !== RPC) begin errors++; $display("FAIL reset imem_addr: got %h, want %h", imem_addr, RPC); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, want 0", out_valid); end
        if (out_inst !== 32'h0) begin errors++; $display("FAIL reset out_inst: got %h, want 0", out_inst); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL reset out_pc: got %h, want 0", out_pc); end
        if (out_next_pc !== 32'h4) begin errors++; $display("FAIL reset out_next_pc: got %h, want 4", out_next_pc); end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset first cycle imem_req: got %b, want 0", imem_req); end
        @(negedge CLK);
        checks += 2;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL reset second cycle imem_req: got %b, want 1", imem_req); end
        if (imem_addr !== RPC) begin errors++; $display("FAIL reset first fetch addr: got %h, want %h", imem_addr, RPC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        cyc(24);
        checks++;
        if (pop_pc_q.size() < 6) begin errors++; $display("FAIL stream count: got %0d, want >= 6", pop_pc_q.size()); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            exp_pc = RPC + 32'(4 * i);
            checks++;
            if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stream[%0d]: got pc=%h inst=%h next=%h, want pc=%h inst=%h next=%h",
                         i, pop_pc_q[i], pop_inst_q[i], pop_next_q[i], exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
        end
        checks++;
        if (anom_cnt !== 0) begin errors++; $display("FAIL stream protocol: got %0d anomalies (code %0d), want 0", anom_cnt, anom_code); end
        anom_cnt = 0; anom_code = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        bit found;
        int g0;
        gnt_pct = 100; dly_min = 0; dly_max = 0;
        do_redirect(32'h0000_0200);
        clear_pops();
        out_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            cyc(1);
            if (m_count == DEPTH) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL backpressure fill: occupancy %0d, want %0d", m_count, DEPTH); end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks += 2;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL backpressure full req: got %b, want 0", imem_req); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL backpressure full valid: got %b, want 1", out_valid); end
        end
        @(posedge CLK); #1;
        g0 = grants;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        cyc(10);
        checks++;
        if (grants - g0 != 1) begin errors++; $display("FAIL backpressure single pop: got %0d requests, want 1", grants - g0); end
        out_ready = 1'b1;
        cyc(20);
        checks++;
        if (pop_pc_q.size() < DEPTH + 1) begin errors++; $display("FAIL backpressure drain count: got %0d, want >= %0d", pop_pc_q.size(), DEPTH + 1); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            exp_pc = 32'h0000_0200 + 32'(4 * i);
            checks++;
            if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL backpressure[%0d]: got pc=%h inst=%h next=%h, want pc=%h inst=%h",
                         i, pop_pc_q[i], pop_inst_q[i], pop_next_q[i], exp_pc, mem_word(exp_pc));
            end
        end
        checks++;
        if (anom_cnt !== 0) begin errors++; $display("FAIL backpressure protocol: got %0d anomalies (code %0d), want 0", anom_cnt, anom_code); end
        anom_cnt = 0; anom_code = 0;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] exp_pc;
        bit found;
        int g0;
        gnt_pct = 100; dly_min = 3; dly_max = 3; out_ready = 1'b1;
        do_redirect(32'h0000_0040);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge CLK);
            if (imem_req === 1'b1 && imem_gnt === 1'b1) found = 1;
        end
        @(posedge CLK); #1;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redirect_wait valid N: got %b, want 0", out_valid); end
        @(posedge CLK); #1;
        redirect = 1'b0;
        clear_pops();
        g0 = grants;
        @(negedge CLK);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redirect_wait valid N+1: got %b, want 0", out_valid); end
        if (imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redirect_wait addr: got %h, want 00000100", imem_addr); end
        for (int k = 0; k < 30 && grants == g0; k++) cyc(1);
        checks++;
        if (grants == g0 || last_acc !== 32'h0000_0100) begin errors++; $display("FAIL redirect_wait next request: got %h (grants %0d), want 00000100", last_acc, grants - g0); end
        cyc(25);
        checks++;
        if (pop_pc_q.size() < 1) begin errors++; $display("FAIL redirect_wait count: got %0d, want >= 1", pop_pc_q.size()); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            exp_pc = 32'h0000_0100 + 32'(4 * i);
            checks++;
            if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL redirect_wait[%0d]: got pc=%h inst=%h, want pc=%h inst=%h",
                         i, pop_pc_q[i], pop_inst_q[i], exp_pc, mem_word(exp_pc));
            end
        end
        checks++;
        if (anom_cnt !== 0) begin errors++; $display("FAIL redirect_wait protocol: got %0d anomalies (code %0d), want 0", anom_cnt, anom_code); end
        anom_cnt = 0; anom_code = 0;
    endtask

    task automatic test_redirect_collision();
        logic [31:0] exp_pc;
        bit found;
        int g0;
        gnt_pct = 100; dly_min = 1; dly_max = 1;
        do_redirect(32'h0000_0080);
        out_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge CLK); #2;
            if (imem_rvalid === 1'b1 && out_valid === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL collision setup: no cycle with rvalid and out_valid, want one"); end
        redirect = 1'b1; redirect_pc = 32'h0000_0300; out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL collision valid N: got %b, want 0", out_valid); end
        @(posedge CLK); #1;
        redirect = 1'b0;
        clear_pops();
        g0 = grants;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL collision valid N+1: got %b, want 0", out_valid); end
        for (int k = 0; k < 30 && grants == g0; k++) cyc(1);
        checks++;
        if (grants == g0 || last_acc !== 32'h0000_0300) begin errors++; $display("FAIL collision next request: got %h (grants %0d), want 00000300", last_acc, grants - g0); end
        cyc(20);
        checks++;
        if (pop_pc_q.size() < 1) begin errors++; $display("FAIL collision count: got %0d, want >= 1", pop_pc_q.size()); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            exp_pc = 32'h0000_0300 + 32'(4 * i);
            checks++;
            if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL collision[%0d]: got pc=%h inst=%h, want pc=%h inst=%h",
                         i, pop_pc_q[i], pop_inst_q[i], exp_pc, mem_word(exp_pc));
            end
        end
        checks++;
        if (anom_cnt !== 0) begin errors++; $display("FAIL collision protocol: got %0d anomalies (code %0d), want 0", anom_cnt, anom_code); end
        anom_cnt = 0; anom_code = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        gnt_pct = 100; dly_min = 0; dly_max = 0; out_ready = 1'b1;
        do_redirect(32'hFFFF_FFF8);
        clear_pops();
        cyc(16);
        checks++;
        if (pop_pc_q.size() < 3) begin
            errors++; $display("FAIL wrap count: got %0d, want >= 3", pop_pc_q.size());
        end else begin
            checks += 2;
            if (pop_pc_q[2] !== 32'h0) begin errors++; $display("FAIL wrap pc after top: got %h, want 00000000", pop_pc_q[2]); end
            if (pop_next_q[1] !== 32'h0) begin errors++; $display("FAIL wrap next_pc at fffffffc: got %h, want 00000000", pop_next_q[1]); end
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
            checks++;
            if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL wrap[%0d]: got pc=%h inst=%h next=%h, want pc=%h inst=%h next=%h",
                         i, pop_pc_q[i], pop_inst_q[i], pop_next_q[i], exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
        end
        checks++;
        if (anom_cnt !== 0) begin errors++; $display("FAIL wrap protocol: got %0d anomalies (code %0d), want 0", anom_cnt, anom_code); end
        anom_cnt = 0; anom_code = 0;
    endtask

    task automatic test_random();
        logic [31:0] base, exp_pc;
        for (int seg = 0; seg < 6; seg++) begin
            gnt_pct = $urandom_range(100, 30);
            dly_min = 0;
            dly_max = $urandom_range(3, 0);
            base    = $urandom;
            if (seg == 5) base = 32'hFFFF_FFE0 | ($urandom & 32'h0000_001F);
            do_redirect(base);
            base = base & 32'hFFFF_FFFC;
            clear_pops();
            for (int k = 0; k < 60; k++) begin
                out_ready = ($urandom_range(99, 0) < 60);
                cyc(1);
            end
            checks++;
            if (pop_pc_q.size() < 1) begin errors++; $display("FAIL random seg%0d count: got %0d, want >= 1", seg, pop_pc_q.size()); end
            for (int i = 0; i < pop_pc_q.size(); i++) begin
                exp_pc = base + 32'(4 * i);
                checks++;
                if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL random seg%0d[%0d]: got pc=%h inst=%h next=%h, want pc=%h inst=%h",
                             seg, i, pop_pc_q[i], pop_inst_q[i], pop_next_q[i], exp_pc, mem_word(exp_pc));
                end
            end
            checks++;
            if (anom_cnt !== 0) begin errors++; $display("FAIL random seg%0d protocol: got %0d anomalies (code %0d), want 0", seg, anom_cnt, anom_code); end
            anom_cnt = 0; anom_code = 0;
        end
    endtask

    task automatic test_reset_midwait();
        logic [31:0] exp_pc;
        bit found;
        gnt_pct = 100; dly_min = 4; dly_max = 4; out_ready = 1'b0;
        do_redirect(32'h0000_0500);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            cyc(1);
            if (m_count == 2) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_midwait fill: occupancy %0d, want 2", m_count); end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (imem_req === 1'b1 && imem_gnt === 1'b1) found = 1;
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        dly_min = 0; dly_max = 0;
        @(negedge CLK);
        checks += 6;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_midwait imem_req: got %b, want 0", imem_req); end
        if (imem_addr !== RPC) begin errors++; $display("FAIL reset_midwait imem_addr: got %h, want %h", imem_addr, RPC); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_midwait out_valid: got %b, want 0", out_valid); end
        if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_midwait out_inst: got %h, want 0", out_inst); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_midwait out_pc: got %h, want 0", out_pc); end
        if (out_next_pc !== 32'h4) begin errors++; $display("FAIL reset_midwait out_next_pc: got %h, want 4", out_next_pc); end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        cyc(30);
        checks++;
        if (pop_pc_q.size() < 3) begin errors++; $display("FAIL reset_midwait count: got %0d, want >= 3", pop_pc_q.size()); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            exp_pc = RPC + 32'(4 * i);
            checks++;
            if (pop_pc_q[i] !== exp_pc || pop_inst_q[i] !== mem_word(exp_pc) || pop_next_q[i] !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL reset_midwait[%0d]: got pc=%h inst=%h, want pc=%h inst=%h",
                         i, pop_pc_q[i], pop_inst_q[i], exp_pc, mem_word(exp_pc));
            end
        end
        checks++;
        if (anom_cnt !== 0) begin errors++; $display("FAIL reset_midwait protocol: got %0d anomalies (code %0d), want 0", anom_cnt, anom_code); end
        anom_cnt = 0; anom_code = 0;
    endtask

    initial begin
        RST = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_collision();
        test_wrap();
        test_random();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the single-cycle RV32 datapath. It owns the fetch program counter and issues word requests to an instruction memory that may stall or return data late. Returned instructions are buffered with their PCs in a small FIFO and handed to decode over a valid/ready handshake. A redirect input flushes buffered and in-flight fetches and restarts fetching at a new address.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; one clock, reset is synchronous and active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; always word-aligned ([1:0]=00)
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid for the oldest accepted request
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 00
- out_valid  out  1  head entry is valid for decode
- out_ready  in  1  decode consumes the head entry
- out_inst  out  32  head instruction
- out_pc  out  32  head PC
- out_next_pc  out  32  out_pc + 4, modulo 2^32

## Operation
- State: fetch_pc (32), FIFO of DEPTH × {pc, inst}, count (0..DEPTH), FSM {IDLE, REQ, WAIT, DROP}.
- At most one outstanding memory request at any time. imem_req = (state==REQ). imem_addr = fetch_pc.
- Space rule: a request is issued only if count + 1 ≤ DEPTH after accounting for a same-cycle pop. This guarantees a slot for every accepted request.
- IDLE: if space exists → REQ; otherwise stay.
- REQ: when imem_gnt=1 → WAIT. Without a grant, imem_req stays asserted and imem_addr stays stable.
- WAIT: when imem_rvalid=1:
  - push {fetch_pc, imem_rdata};
  - fetch_pc += 4 (0xFFFF_FFFC wraps to 0);
  - go to REQ if space remains after this cycle's push/pop, else IDLE.
- DROP: waits for the response to a stale request. On imem_rvalid=1 the data is discarded, fetch_pc is unchanged, and the FSM goes to REQ.
- Pop: when out_valid && out_ready, the head advances. Push and pop in the same cycle leave count unchanged.
- out_valid = (count≠0) && !redirect. out_inst/out_pc show the head entry; their value is don't-care when out_valid=0.
- Redirect has priority over every other event in that cycle:
  - count ← 0 and FIFO pointers reset; any same-cycle pop has no effect;
  - fetch_pc ← {redirect_pc[31:2], 2'b00};
  - WAIT with rvalid=0 → DROP; WAIT with rvalid=1 → REQ (data discarded);
  - REQ with gnt=1 → DROP (the granted request is stale); REQ with gnt=0 → REQ at the new address;
  - IDLE → REQ;
  - DROP with rvalid=0 → DROP; DROP with rvalid=1 → REQ.
- RST overrides redirect.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, out_next_pc=4, count=0, all FIFO storage=0, state=IDLE.
- First cycle after RST deasserts: IDLE→REQ. imem_req rises in the second cycle after deassertion.
- A request is accepted on the edge where imem_req && imem_gnt. The earliest imem_rvalid is the following cycle. imem_rvalid outside WAIT/DROP is ignored.
- Pushed data appears on out_* the cycle after the rvalid edge (1-cycle fill latency).
- Peak throughput is one instruction per 2 cycles (REQ→WAIT→REQ) when gnt and rvalid are immediate.
- Full FIFO (count=DEPTH): no request is issued and state=IDLE. A pop in the IDLE cycle permits REQ on the next cycle.
- Empty FIFO: out_valid=0, and out_ready is ignored.
- redirect in cycle N: out_valid=0 in cycle N and N+1. The first redirected instruction is valid no earlier than N+3 (N+4 if DROP was entered).

## Test plan
- Reset, then gnt and rvalid both immediate, out_ready=1: out_pc sequence 0x0,0x4,0x8 with out_inst matching the memory image; out_next_pc=out_pc+4; imem_req=0 during RST.
- out_ready=0, fetch 4 words at DEPTH=4 → count=4, imem_req stays 0. Raise out_ready for 1 cycle → exactly one new request is issued. No entry is lost or duplicated.
- Assert redirect to 0x0000_0103 while in WAIT with rvalid delayed 3 cycles → the late data is discarded (never on out_*). The next imem_addr is 0x0000_0100, and the first out_pc is 0x100.
- Assert redirect in the same cycle as out_valid&&out_ready and imem_rvalid → the queue ends empty, there is no pop side effect, and the next request address is the redirect target.
- Set fetch_pc near the top via redirect to 0xFFFF_FFF8 → out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0. out_next_pc at 0xFFFFFFFC equals 0.
- Assert RST while in WAIT with 2 entries buffered → the next cycle shows all reset values; a stale rvalid arriving after reset is ignored.
